// File: rtl/lsq_idx_alloc.sv
// Load/store queue index allocator: hands out {flipped,idx} entries to in-order dispatch lanes, frees on commit, rewinds tails on squash.
// Indices and ready are combinational from registered pointers; groups dispatch all-or-nothing and stall while space is short or a squash is active.
module lsq_idx_alloc #(
  parameter int LQSIZE       = 64,
  parameter int SQSIZE       = 64,
  parameter int DISP_WIDTH   = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int LQW = $clog2(LQSIZE),
  localparam int SQW = $clog2(SQSIZE),
  localparam int CW  = $clog2(COMMIT_WIDTH + 1),
  localparam int DW  = $clog2(DISP_WIDTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [DISP_WIDTH-1:0]            i_disp_vld,
  input  logic [DISP_WIDTH-1:0]            i_disp_isld,
  input  logic [DISP_WIDTH-1:0]            i_disp_isst,
  output logic                             o_disp_rdy,
  output logic [DISP_WIDTH-1:0][LQW:0]     o_lqIdx,
  output logic [DISP_WIDTH-1:0][SQW:0]     o_sqIdx,
  input  logic [CW-1:0]                    i_lq_commit_num,
  input  logic [CW-1:0]                    i_sq_commit_num,
  input  logic                             i_squash_vld,
  input  logic [LQW:0]                     i_squash_lqIdx,
  input  logic [SQW:0]                     i_squash_sqIdx,
  output logic [LQW:0]                     o_lq_head,
  output logic [SQW:0]                     o_sq_head,
  output logic [LQW:0]                     o_lq_free,
  output logic [SQW:0]                     o_sq_free
);

  localparam logic [LQW:0] LQ_SIZE_P = (LQW+1)'(LQSIZE);
  localparam logic [SQW:0] SQ_SIZE_P = (SQW+1)'(SQSIZE);

  // Pointers carry the flipped bit as MSB, so plain (W+1)-bit arithmetic
  // wraps the index mod SIZE and toggles flipped whenever the sum crosses SIZE.
  logic [LQW:0] lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;
  logic [SQW:0] sq_head_q, sq_head_d, sq_tail_q, sq_tail_d;

  logic [LQW:0] lq_occ, lq_free;
  logic [SQW:0] sq_occ, sq_free;
  logic [DW-1:0] lq_run, sq_run;
  logic [DW-1:0] nld, nst;
  logic          fire;

  // Occupancy is tail-head mod 2*SIZE: covers both equal and differing flipped bits.
  assign lq_occ  = lq_tail_q - lq_head_q;
  assign sq_occ  = sq_tail_q - sq_head_q;
  assign lq_free = LQ_SIZE_P - lq_occ;
  assign sq_free = SQ_SIZE_P - sq_occ;

  always_comb begin
    lq_run  = '0;
    sq_run  = '0;
    o_lqIdx = '0;
    o_sqIdx = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      o_lqIdx[k] = lq_tail_q + (LQW+1)'(lq_run);
      o_sqIdx[k] = sq_tail_q + (SQW+1)'(sq_run);
      if (i_disp_vld[k] && i_disp_isld[k]) lq_run = lq_run + DW'(1);
      if (i_disp_vld[k] && i_disp_isst[k]) sq_run = sq_run + DW'(1);
    end
    nld = lq_run;
    nst = sq_run;
  end

  assign o_disp_rdy = ((LQW+1)'(nld) <= lq_free) &&
                      ((SQW+1)'(nst) <= sq_free) &&
                      !i_squash_vld;
  assign fire       = (|i_disp_vld) && o_disp_rdy;

  always_comb begin
    lq_head_d = lq_head_q + (LQW+1)'(i_lq_commit_num);
    sq_head_d = sq_head_q + (SQW+1)'(i_sq_commit_num);
    lq_tail_d = lq_tail_q;
    sq_tail_d = sq_tail_q;
    if (i_squash_vld) begin
      lq_tail_d = i_squash_lqIdx;
      sq_tail_d = i_squash_sqIdx;
    end else if (fire) begin
      lq_tail_d = lq_tail_q + (LQW+1)'(nld);
      sq_tail_d = sq_tail_q + (SQW+1)'(nst);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lq_head_q <= '0;
      lq_tail_q <= '0;
      sq_head_q <= '0;
      sq_tail_q <= '0;
    end else begin
      lq_head_q <= lq_head_d;
      lq_tail_q <= lq_tail_d;
      sq_head_q <= sq_head_d;
      sq_tail_q <= sq_tail_d;
    end
  end

  assign o_lq_head = lq_head_q;
  assign o_sq_head = sq_head_q;
  assign o_lq_free = lq_free;
  assign o_sq_free = sq_free;

  // Distance of the squash point from head must not exceed current occupancy.
  logic [LQW:0] lq_squash_dist;
  logic [SQW:0] sq_squash_dist;
  assign lq_squash_dist = i_squash_lqIdx - lq_head_q;
  assign sq_squash_dist = i_squash_sqIdx - sq_head_q;

  a_lq_commit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (LQW+1)'(i_lq_commit_num) <= lq_occ);
  a_sq_commit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (SQW+1)'(i_sq_commit_num) <= sq_occ);
  a_ld_st_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (i_disp_vld & i_disp_isld & i_disp_isst) == '0);
  a_lq_squash: assert property (@(posedge clk_i) disable iff (!rst_ni)
    i_squash_vld |-> (lq_squash_dist <= lq_occ));
  a_sq_squash: assert property (@(posedge clk_i) disable iff (!rst_ni)
    i_squash_vld |-> (sq_squash_dist <= sq_occ));

endmodule

// File: tb/tb_lsq_idx_alloc.sv
// Directed bench for lsq_idx_alloc: a vector table run from reset plus hand sequences for full, wrap, squash and mid-run reset.
module tb_lsq_idx_alloc;
  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [3:0]      i_disp_vld, i_disp_isld, i_disp_isst;
  logic            o_disp_rdy;
  logic [3:0][6:0] o_lqIdx, o_sqIdx;
  logic [2:0]      i_lq_commit_num, i_sq_commit_num;
  logic            i_squash_vld;
  logic [6:0]      i_squash_lqIdx, i_squash_sqIdx;
  logic [6:0]      o_lq_head, o_sq_head, o_lq_free, o_sq_free;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk_i = ~clk_i;

  lsq_idx_alloc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_disp_vld(i_disp_vld), .i_disp_isld(i_disp_isld), .i_disp_isst(i_disp_isst),
    .o_disp_rdy(o_disp_rdy), .o_lqIdx(o_lqIdx), .o_sqIdx(o_sqIdx),
    .i_lq_commit_num(i_lq_commit_num), .i_sq_commit_num(i_sq_commit_num),
    .i_squash_vld(i_squash_vld), .i_squash_lqIdx(i_squash_lqIdx), .i_squash_sqIdx(i_squash_sqIdx),
    .o_lq_head(o_lq_head), .o_sq_head(o_sq_head), .o_lq_free(o_lq_free), .o_sq_free(o_sq_free)
  );

  typedef struct {
    logic [3:0] vld, isld, isst;
    int         lqc, sqc;
    logic       sqv;
    int         sql, sqs;
    logic       rdy;
    int         lqi[4];
    int         sqi[4];
    int         lqf, sqf, lqh, sqh;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic [3:0] vld, logic [3:0] isld, logic [3:0] isst,
                              int lqc, int sqc, logic sqv, int sql, int sqs, logic rdy,
                              int l0, int l1, int l2, int l3, int s0, int s1, int s2, int s3,
                              int lqf, int sqf, int lqh, int sqh);
    vec_t v;
    v.vld = vld; v.isld = isld; v.isst = isst;
    v.lqc = lqc; v.sqc = sqc; v.sqv = sqv; v.sql = sql; v.sqs = sqs; v.rdy = rdy;
    v.lqi[0] = l0; v.lqi[1] = l1; v.lqi[2] = l2; v.lqi[3] = l3;
    v.sqi[0] = s0; v.sqi[1] = s1; v.sqi[2] = s2; v.sqi[3] = s3;
    v.lqf = lqf; v.sqf = sqf; v.lqh = lqh; v.sqh = sqh;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] isld, input logic [3:0] isst,
                       input int lqc, input int sqc);
    i_disp_vld      = vld;
    i_disp_isld     = isld;
    i_disp_isst     = isst;
    i_lq_commit_num = 3'(lqc);
    i_sq_commit_num = 3'(sqc);
    i_squash_vld    = 1'b0;
    i_squash_lqIdx  = '0;
    i_squash_sqIdx  = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 4'h0, 0, 0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    //            vld   isld  isst  lqc sqc sqv sql sqs rdy  lqIdx lanes0..3  sqIdx lanes0..3 lqf sqf lqh sqh
    vecs[0] = mk(4'hF, 4'h5, 4'hA, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 1, 1, 62, 62, 0, 0);
    vecs[1] = mk(4'h7, 4'h7, 4'h0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 2, 2, 2, 2, 59, 62, 0, 0);
    vecs[2] = mk(4'h9, 4'h1, 4'h8, 3, 2, 0, 0, 0, 1, 5, 6, 6, 6, 2, 2, 2, 2, 61, 63, 3, 2);
    vecs[3] = mk(4'hF, 4'hF, 4'h0, 0, 0, 1, 4, 2, 0, 6, 7, 8, 9, 3, 3, 3, 3, 63, 64, 3, 2);
    vecs[4] = mk(4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 4, 4, 4, 4, 2, 2, 2, 2, 64, 64, 4, 2);
    vecs[5] = mk(4'hF, 4'h0, 4'hF, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4, 2, 3, 4, 5, 64, 60, 4, 2);
    vecs[6] = mk(4'h3, 4'h1, 4'h2, 0, 4, 0, 0, 0, 1, 4, 5, 5, 5, 6, 6, 7, 7, 63, 63, 4, 6);

    drive(4'h0, 4'h0, 4'h0, 0, 0);
    #3;
    tick();
    rst_ni = 1'b1;
    chk("reset lq_head", int'(o_lq_head), 0);
    chk("reset sq_head", int'(o_sq_head), 0);
    chk("reset lq_free", int'(o_lq_free), 64);
    chk("reset sq_free", int'(o_sq_free), 64);
    chk("reset rdy", int'(o_disp_rdy), 1);
    chk("reset lq_tail", int'(o_lqIdx[0]), 0);
    chk("reset sq_tail", int'(o_sqIdx[0]), 0);

    for (int r = 0; r < 7; r++) begin
      drive(vecs[r].vld, vecs[r].isld, vecs[r].isst, vecs[r].lqc, vecs[r].sqc);
      i_squash_vld   = vecs[r].sqv;
      i_squash_lqIdx = 7'(vecs[r].sql);
      i_squash_sqIdx = 7'(vecs[r].sqs);
      #2;
      chk($sformatf("vec%0d rdy", r), int'(o_disp_rdy), int'(vecs[r].rdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d lqIdx[%0d]", r, k), int'(o_lqIdx[k]), vecs[r].lqi[k]);
        chk($sformatf("vec%0d sqIdx[%0d]", r, k), int'(o_sqIdx[k]), vecs[r].sqi[k]);
      end
      tick();
      chk($sformatf("vec%0d lq_free", r), int'(o_lq_free), vecs[r].lqf);
      chk($sformatf("vec%0d sq_free", r), int'(o_sq_free), vecs[r].sqf);
      chk($sformatf("vec%0d lq_head", r), int'(o_lq_head), vecs[r].lqh);
      chk($sformatf("vec%0d sq_head", r), int'(o_sq_head), vecs[r].sqh);
    end

    // LQ at 63/64: a 2-load group stalls while a commit frees one slot, then fills the queue.
    do_reset();
    repeat (15) begin drive(4'hF, 4'hF, 4'h0, 0, 0); tick(); end
    drive(4'h7, 4'h7, 4'h0, 0, 0); tick();
    chk("fill lq_free", int'(o_lq_free), 1);
    drive(4'h3, 4'h3, 4'h0, 1, 0);
    #2;
    chk("fill stall rdy", int'(o_disp_rdy), 0);
    tick();
    chk("fill stall tail", int'(o_lqIdx[0]), 63);
    chk("fill commit free", int'(o_lq_free), 2);
    chk("fill commit head", int'(o_lq_head), 1);
    drive(4'h3, 4'h3, 4'h0, 0, 0);
    #2;
    chk("fill retry rdy", int'(o_disp_rdy), 1);
    tick();
    drive(4'h1, 4'h1, 4'h0, 0, 0);
    #2;
    chk("full lq_free", int'(o_lq_free), 0);
    chk("full lq_head", int'(o_lq_head), 1);
    chk("full lq_tail", int'(o_lqIdx[0]), 65);
    chk("full load rdy", int'(o_disp_rdy), 0);
    drive(4'h1, 4'h0, 4'h1, 0, 0);
    #1;
    chk("full store rdy", int'(o_disp_rdy), 1);
    drive(4'h0, 4'h0, 4'h0, 0, 0);

    // Wrap: head {0,60}, tail {0,62}, four loads straddle the end of the queue.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(4'hF, 4'hF, 4'h0, (i > 0) ? 4 : 0, 0);
      tick();
    end
    drive(4'h3, 4'h3, 4'h0, 4, 0); tick();
    chk("wrap pre head", int'(o_lq_head), 60);
    chk("wrap pre free", int'(o_lq_free), 62);
    drive(4'hF, 4'hF, 4'h0, 0, 0);
    #2;
    chk("wrap lane0", int'(o_lqIdx[0]), 62);
    chk("wrap lane1", int'(o_lqIdx[1]), 63);
    chk("wrap lane2", int'(o_lqIdx[2]), 64);
    chk("wrap lane3", int'(o_lqIdx[3]), 65);
    tick();
    drive(4'h0, 4'h0, 4'h0, 0, 0);
    #1;
    chk("wrap tail", int'(o_lqIdx[0]), 66);
    chk("wrap free", int'(o_lq_free), 58);

    // Squash with a valid dispatch group: nothing fires, tails rewind.
    do_reset();
    drive(4'hF, 4'hF, 4'h0, 0, 0); tick(); tick();
    drive(4'hF, 4'h0, 4'hF, 0, 0); tick();
    drive(4'h3, 4'h0, 4'h3, 0, 0); tick();
    drive(4'hF, 4'hF, 4'h0, 0, 0);
    i_squash_vld   = 1'b1;
    i_squash_lqIdx = 7'd5;
    i_squash_sqIdx = 7'd3;
    #2;
    chk("squash rdy", int'(o_disp_rdy), 0);
    tick();
    drive(4'h0, 4'h0, 4'h0, 0, 0);
    #1;
    chk("squash lq_free", int'(o_lq_free), 59);
    chk("squash sq_free", int'(o_sq_free), 61);
    chk("squash lq_tail", int'(o_lqIdx[0]), 5);
    chk("squash sq_tail", int'(o_sqIdx[0]), 3);

    // Commit 3 and fire 2 in the same cycle from head 0, tail 10.
    do_reset();
    drive(4'hF, 4'hF, 4'h0, 0, 0); tick(); tick();
    drive(4'h3, 4'h3, 4'h0, 0, 0); tick();
    drive(4'h3, 4'h3, 4'h0, 3, 0); tick();
    drive(4'h0, 4'h0, 4'h0, 0, 0);
    #1;
    chk("cf lq_head", int'(o_lq_head), 3);
    chk("cf lq_tail", int'(o_lqIdx[0]), 12);
    chk("cf lq_free", int'(o_lq_free), 55);

    // Reset asserted between clock edges clears pointers immediately.
    drive(4'hF, 4'hF, 4'h0, 0, 0);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async rst lq_head", int'(o_lq_head), 0);
    chk("async rst lq_tail", int'(o_lqIdx[0]), 0);
    chk("async rst lq_free", int'(o_lq_free), 64);
    drive(4'h0, 4'h0, 4'h0, 0, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post rst lq_free", int'(o_lq_free), 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
